// File: rtl/avalon_led_pwm_pkg.sv
// Shared register map and read-FSM state encoding for the Avalon LED PWM block.
package avalon_led_pwm_pkg;

    localparam int ADDR_CTRL         = 0;
    localparam int ADDR_LED_ON       = 1;
    localparam int ADDR_BLINK_MASK   = 2;
    localparam int ADDR_BLINK_PERIOD = 3;
    localparam int ADDR_DUTY_BASE    = 4;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t RD_IDLE = 1'b0;
    localparam rd_state_t RD_RESP = 1'b1;

endpackage

// File: rtl/avalon_led_pwm_if.sv
// Avalon-MM slave bundle for the LED PWM block; master side drives requests.
interface avalon_led_pwm_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (output address, read, write, writedata, input readdata, waitrequest);
    modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/led_pwm_chan.sv
// One PWM channel: active while the shared counter is below duty; all-ones duty is solid on.
module led_pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic [PWM_BITS-1:0] i_cnt,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_active
);
    // The plain compare can never reach 100%, so all-ones is forced on.
    assign o_active = (&i_duty) | (i_cnt < i_duty);
endmodule

// File: rtl/avalon_led_pwm.sv
// Avalon-MM LED PWM controller with per-channel duty and optional blink gating.
// Blink counter, BLINK_MASK and BLINK_PERIOD exist only when AVALON_LED_PWM_BLINK_EN is defined.
module avalon_led_pwm
    import avalon_led_pwm_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8,
    parameter int ADDR_W   = 6
) (
    input  logic                clock_clk,
    input  logic                reset_reset,
    input  logic [ADDR_W-1:0]   avs_s0_address,
    input  logic                avs_s0_read,
    output logic [31:0]         avs_s0_readdata,
    input  logic                avs_s0_write,
    input  logic [31:0]         avs_s0_writedata,
    output logic                avs_s0_waitrequest,
    output logic [NUM_LEDS-1:0] leds
);

    logic [31:0]                        w_addr;
    logic                               w_wr_ctrl;
    logic                               w_wr_on;
    logic [NUM_LEDS-1:0]                w_wr_duty;
    logic [NUM_LEDS-1:0]                w_active;
    logic [NUM_LEDS-1:0]                w_blink_gate;
    logic [31:0]                        w_rdata;
    logic                               w_unused_wdata;

    logic                               r_en;
    logic [NUM_LEDS-1:0]                r_led_on;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  r_duty;
    logic [PWM_BITS-1:0]                r_pwm_cnt;
    logic [NUM_LEDS-1:0]                r_leds;
    rd_state_t                          r_state;
    logic [31:0]                        r_readdata;

    assign w_addr         = 32'(avs_s0_address);
    assign w_wr_ctrl      = avs_s0_write && (w_addr == 32'(ADDR_CTRL));
    assign w_wr_on        = avs_s0_write && (w_addr == 32'(ADDR_LED_ON));
    assign w_unused_wdata = &{1'b0, avs_s0_writedata};

    always_comb begin
        w_wr_duty = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            w_wr_duty[i] = avs_s0_write && (w_addr == 32'(ADDR_DUTY_BASE + i));
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            r_en      <= 1'b0;
            r_led_on  <= '0;
            r_duty    <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (w_wr_ctrl) r_en     <= avs_s0_writedata[0];
            if (w_wr_on)   r_led_on <= avs_s0_writedata[NUM_LEDS-1:0];
            for (int i = 0; i < NUM_LEDS; i++)
                if (w_wr_duty[i]) r_duty[i] <= avs_s0_writedata[PWM_BITS-1:0];
        end
    end

`ifdef AVALON_LED_PWM_BLINK_EN
    logic [NUM_LEDS-1:0] r_blink_mask;
    logic [31:0]         r_blink_period;
    logic [31:0]         r_blink_cnt;
    logic                r_blink_phase;

    // A period write restarts the blink cycle in the lit phase.
    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            r_blink_mask   <= '0;
            r_blink_period <= '0;
            r_blink_cnt    <= '0;
            r_blink_phase  <= 1'b1;
        end else begin
            if (avs_s0_write && (w_addr == 32'(ADDR_BLINK_MASK)))
                r_blink_mask <= avs_s0_writedata[NUM_LEDS-1:0];
            if (avs_s0_write && (w_addr == 32'(ADDR_BLINK_PERIOD))) begin
                r_blink_period <= avs_s0_writedata;
                r_blink_cnt    <= '0;
                r_blink_phase  <= 1'b1;
            end else if (r_blink_period == '0) begin
                r_blink_cnt    <= '0;
                r_blink_phase  <= 1'b1;
            end else if (r_blink_cnt == r_blink_period) begin
                r_blink_cnt    <= '0;
                r_blink_phase  <= ~r_blink_phase;
            end else begin
                r_blink_cnt    <= r_blink_cnt + 32'd1;
            end
        end
    end

    assign w_blink_gate = {NUM_LEDS{r_blink_phase}} | ~r_blink_mask;
`else
    assign w_blink_gate = '1;
`endif

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan (
            .i_cnt    (r_pwm_cnt),
            .i_duty   (r_duty[g]),
            .o_active (w_active[g])
        );
    end

    always_ff @(posedge clock_clk) begin
        if (reset_reset) r_leds <= '0;
        else             r_leds <= {NUM_LEDS{r_en}} & r_led_on & w_active & w_blink_gate;
    end
    assign leds = r_leds;

    always_comb begin
        w_rdata = '0;
        if (w_addr == 32'(ADDR_CTRL))
            w_rdata[0] = r_en;
        else if (w_addr == 32'(ADDR_LED_ON))
            w_rdata[NUM_LEDS-1:0] = r_led_on;
`ifdef AVALON_LED_PWM_BLINK_EN
        else if (w_addr == 32'(ADDR_BLINK_MASK))
            w_rdata[NUM_LEDS-1:0] = r_blink_mask;
        else if (w_addr == 32'(ADDR_BLINK_PERIOD))
            w_rdata = r_blink_period;
`endif
        for (int i = 0; i < NUM_LEDS; i++)
            if (w_addr == 32'(ADDR_DUTY_BASE + i)) w_rdata[PWM_BITS-1:0] = r_duty[i];
    end

    // Each read stalls exactly one cycle; a colliding write wins and the read returns 0.
    assign avs_s0_waitrequest = (r_state == RD_IDLE) && avs_s0_read;
    assign avs_s0_readdata    = r_readdata;

    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            r_state    <= RD_IDLE;
            r_readdata <= '0;
        end else begin
            case (r_state)
                RD_IDLE: if (avs_s0_read) begin
                    r_readdata <= avs_s0_write ? 32'd0 : w_rdata;
                    r_state    <= RD_RESP;
                end
                RD_RESP: r_state <= RD_IDLE;
                default: r_state <= RD_IDLE;
            endcase
        end
    end

endmodule
